// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debouncer
//  Description : Push-button debouncer. A 2-FF synchroniser feeds a stability
//                counter; the debounced level only changes once the
//                synchronised input has disagreed with it for COUNT_MAX
//                consecutive cycles. A registered one-cycle pulse is emitted
//                on every accepted press (debounced 0->1 transition).
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic bt_in,
    output logic bt
);

    // Stability length in cycles and the counter sized to hold it.
    localparam int COUNT_MAX = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int CNT_W     = (COUNT_MAX < 1) ? 1 : $clog2(COUNT_MAX + 1);

    // Terminal count: the cycle on which a persistent disagreement is accepted.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(COUNT_MAX - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    // Debounced button level, kept as a two-state machine.
    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_counter;
    logic             r_bt;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_counter_nxt;
    logic             w_bt_nxt;
    logic             w_differs;

    // Two-flop synchroniser; only r_sync2 is used by the logic below.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bt_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_differs = (r_sync2 != logic'(r_state));

    // Next-state logic: count disagreement cycles, accept at terminal count.
    // Any cycle of agreement discards a partial count, so short bounces and
    // glitches never reach the terminal value.
    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = '0;
        w_bt_nxt      = 1'b0;
        if (w_differs) begin
            if (r_counter >= c_LAST) begin
                w_state_nxt = state_t'(r_sync2);
                // Only a release->press transition is reported.
                w_bt_nxt    = (r_state == RELEASED);
            end else begin
                w_counter_nxt = r_counter + c_ONE;
            end
        end
    end

    // State, counter and pulse registers; reset wins over any count in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RELEASED;
            r_counter <= '0;
            r_bt      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_bt      <= w_bt_nxt;
        end
    end

    assign bt = r_bt;

endmodule
`default_nettype wire

// File: tb/tb_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debouncer
//  Description : Self-checking bench for btn_debouncer. Two scaled-down
//                instances: A with COUNT_MAX=20 (1 ms = 2 cycles) and B with
//                COUNT_MAX=4 for boundary timing. Expected pulse cycles are
//                queued by the stimulus and checked by a monitor thread.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debouncer;

    localparam int CM_A = 20;   // 2000 Hz * 10 ms / 1000
    localparam int CM_B = 4;    // 1000 Hz * 4 ms / 1000
    localparam int MS   = 2;    // cycles per "millisecond" on instance A
    localparam int HOLD = 600;  // "300 ms" on instance A

    logic clk = 1'b0;
    logic rst_a, bt_in_a, bt_a;
    logic rst_b, bt_in_b, bt_b;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int q_a[$];
    int q_b[$];

    btn_debouncer #(.CLK_FREQ_HZ(2000), .DEBOUNCE_MS(10)) dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .bt_in (bt_in_a),
        .bt    (bt_a)
    );

    btn_debouncer #(.CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4)) dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .bt_in (bt_in_b),
        .bt    (bt_b)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_a   = 1'b1;
        bt_in_a = 1'b1;
        rst_b   = 1'b1;
        bt_in_b = 1'b0;
        fork
            // ---------------- stimulus ----------------
            begin
                // Reset with button already pressed.
                tick(1);
                chk("a_reset_bt", int'(bt_a), 0);
                chk("a_reset_state", int'(dut_a.r_state), 0);
                chk("a_reset_counter", int'(dut_a.r_counter), 0);
                chk("a_reset_sync2", int'(dut_a.r_sync2), 0);

                // Release reset holding pressed: one pulse COUNT_MAX+2 later.
                rst_a = 1'b0;
                q_a.push_back(cyc + 2 + CM_A);
                tick(HOLD);
                chk("a_held_state", int'(dut_a.r_state), 1);

                // Clean release: no pulse, state falls.
                bt_in_a = 1'b0;
                tick(CM_A + 1);
                chk("a_release_state_early", int'(dut_a.r_state), 1);
                tick(HOLD - CM_A - 1);
                chk("a_release_state", int'(dut_a.r_state), 0);

                // Bounce settling to 0: nothing accepted.
                for (int i = 0; i < 8; i++) begin
                    bt_in_a = 1'b1; tick(MS);
                    bt_in_a = 1'b0; tick(MS);
                end
                tick(HOLD);
                chk("a_bounce0_state", int'(dut_a.r_state), 0);

                // Bounce settling to 1: one pulse after the final settle.
                for (int i = 0; i < 7; i++) begin
                    bt_in_a = 1'b1; tick(MS);
                    bt_in_a = 1'b0; tick(MS);
                end
                bt_in_a = 1'b1;
                q_a.push_back(cyc + 2 + CM_A);
                tick(HOLD);
                chk("a_bounce1_state", int'(dut_a.r_state), 1);
                bt_in_a = 1'b0;
                tick(HOLD);

                // Glitch of "5 ms" (10 cycles): counter climbs then clears.
                bt_in_a = 1'b1;
                tick(10);
                chk("a_glitch_counter_mid", int'(dut_a.r_counter), 8);
                bt_in_a = 1'b0;
                tick(2);
                chk("a_glitch_counter_peak", int'(dut_a.r_counter), 10);
                tick(1);
                chk("a_glitch_counter_clear", int'(dut_a.r_counter), 0);
                chk("a_glitch_state", int'(dut_a.r_state), 0);
                tick(50);

                // Exact latency of a clean step.
                bt_in_a = 1'b1;
                q_a.push_back(cyc + 2 + CM_A);
                tick(100);
                bt_in_a = 1'b0;
                tick(100);

                // Reset mid-count: fresh full count afterwards.
                bt_in_a = 1'b1;
                tick(12);
                chk("a_midcount_counter", int'(dut_a.r_counter), 10);
                rst_a = 1'b1;
                tick(1);
                chk("a_rst_mid_counter", int'(dut_a.r_counter), 0);
                chk("a_rst_mid_state", int'(dut_a.r_state), 0);
                chk("a_rst_mid_bt", int'(bt_a), 0);
                rst_a = 1'b0;
                q_a.push_back(cyc + 2 + CM_A);
                tick(200);
                bt_in_a = 1'b0;
                tick(100);

                // Instance B, COUNT_MAX = 4.
                rst_b = 1'b0;
                tick(10);
                chk("b_idle_state", int'(dut_b.r_state), 0);
                bt_in_b = 1'b1;
                q_b.push_back(cyc + 2 + CM_B);
                tick(20);
                bt_in_b = 1'b0;
                tick(20);
                chk("b_release_state", int'(dut_b.r_state), 0);
                // 3-cycle glitch peaks at COUNT_MAX-1 and is rejected.
                bt_in_b = 1'b1;
                tick(3);
                bt_in_b = 1'b0;
                tick(20);
                chk("b_glitch3_state", int'(dut_b.r_state), 0);
                // 4-cycle pulse is exactly long enough to be accepted.
                bt_in_b = 1'b1;
                q_b.push_back(cyc + 2 + CM_B);
                tick(4);
                bt_in_b = 1'b0;
                tick(20);
                chk("b_pulse4_state", int'(dut_b.r_state), 0);
                tick(5);
            end
            // ---------------- monitor ----------------
            begin
                forever begin
                    @(negedge clk);
                    if (bt_a === 1'b1) begin
                        if (q_a.size() == 0) chk("a_unexpected_pulse", 1, 0);
                        else                 chk("a_pulse_cycle", cyc, q_a.pop_front());
                    end
                    if (bt_b === 1'b1) begin
                        if (q_b.size() == 0) chk("b_unexpected_pulse", 1, 0);
                        else                 chk("b_pulse_cycle", cyc, q_b.pop_front());
                    end
                end
            end
        join_any
        chk("a_missing_pulses", q_a.size(), 0);
        chk("b_missing_pulses", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
